// File: rtl/veda_responder_if.sv
// Request/response bus between an initiator (master) and the veda responder (slave).
// Request is valid/ready; the response is held until rsp_ready is seen.
interface veda_responder_if #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_SIZE     = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic                     req_mode;
  logic [1:0]               req_byte_sel;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_SIZE-1:0]     req_wdata;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DATA_SIZE-1:0]     rsp_rdata;
  logic                     rsp_err;

  modport master (
    output req_valid, req_write, req_mode, req_byte_sel, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_mode, req_byte_sel, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/veda_responder.sv
// Word/byte memory responder; one request in flight, response WAIT_CYCLES+1 cycles after accept.
// Backpressure: response held stable until rsp_ready; new requests refused until back in IDLE.
module veda_responder #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_SIZE     = 32,
  parameter int DEPTH         = 48,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  veda_responder_if.slave   bus,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0]             WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDRESS_WIDTH:0] DEPTH_LIM = (ADDRESS_WIDTH+1)'(DEPTH);

  state_t                   state;
  state_t                   state_nxt;
  logic [3:0]               cnt;
  logic                     accept;
  logic                     enter_resp;

  logic                     lat_write;
  logic                     lat_mode;
  logic [1:0]               lat_sel;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [DATA_SIZE-1:0]     lat_wdata;

  logic                     acc_write;
  logic                     acc_mode;
  logic [1:0]               acc_sel;
  logic [ADDRESS_WIDTH-1:0] acc_addr;
  logic [DATA_SIZE-1:0]     acc_wdata;
  logic                     acc_err;

  logic [DATA_SIZE-1:0]     mem [DEPTH];
  logic [DATA_SIZE-1:0]     rd_word;
  logic [7:0]               rd_lane;
  logic [DATA_SIZE-1:0]     rdata_q;
  logic                     err_q;

  assign accept     = (state == IDLE) && bus.req_valid;
  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  // With zero wait states RESP is entered on the accept edge, so use the live request.
  always_comb begin
    acc_write = lat_write;
    acc_mode  = lat_mode;
    acc_sel   = lat_sel;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_write = bus.req_write;
      acc_mode  = bus.req_mode;
      acc_sel   = bus.req_byte_sel;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end
  end

  assign acc_err = ({1'b0, acc_addr} >= DEPTH_LIM);
  assign rd_word = acc_err ? '0 : mem[acc_addr];
  assign rd_lane = rd_word[{acc_sel, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = (WAIT_INIT == 4'd0) ? RESP : WAIT;
      WAIT:    if (cnt <= 4'd1)   state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    busy          = (state != IDLE);
    bus.rsp_valid = (state == RESP);
    bus.rsp_rdata = (state == RESP) ? rdata_q : '0;
    bus.rsp_err   = (state == RESP) && err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_mode  <= 1'b0;
      lat_sel   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= WAIT_INIT;
        lat_write <= bus.req_write;
        lat_mode  <= bus.req_mode;
        lat_sel   <= bus.req_byte_sel;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        err_q <= acc_err;
        if (acc_write || acc_err) rdata_q <= '0;
        else if (acc_mode)        rdata_q <= {{(DATA_SIZE-8){1'b0}}, rd_lane};
        else                      rdata_q <= rd_word;
      end
    end
  end

  // Storage commits only on the edge entering RESP, so a reset during WAIT drops the store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enter_resp && acc_write && !acc_err) begin
      if (acc_mode) mem[acc_addr][{acc_sel, 3'b000} +: 8] <= acc_wdata[7:0];
      else          mem[acc_addr] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_veda_responder.sv
// Directed bench: default build (2 wait states) plus a zero-wait-state build with rsp_ready tied high.
module tb_veda_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy0;
  logic busy1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  veda_responder_if #(.ADDRESS_WIDTH(6), .DATA_SIZE(32)) bus0 ();
  veda_responder_if #(.ADDRESS_WIDTH(6), .DATA_SIZE(32)) bus1 ();

  assign bus1.rsp_ready = 1'b1;

  veda_responder #(.ADDRESS_WIDTH(6), .DATA_SIZE(32), .DEPTH(48), .WAIT_CYCLES(2)) u_dut0 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus0),
    .busy (busy0)
  );

  veda_responder #(.ADDRESS_WIDTH(6), .DATA_SIZE(32), .DEPTH(48), .WAIT_CYCLES(0)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus1),
    .busy (busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on the 2-wait-state build; lat counts edges from accept (inclusive) to rsp_valid.
  task automatic do_req(input logic wr, input logic md, input logic [1:0] sel,
                        input logic [5:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    guard = 0;
    bus0.req_valid    = 1'b1;
    bus0.req_write    = wr;
    bus0.req_mode     = md;
    bus0.req_byte_sel = sel;
    bus0.req_addr     = addr;
    bus0.req_wdata    = wd;
    while (!bus0.req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    lat = 1;
    while (!bus0.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus0.rsp_rdata;
    er = bus0.rsp_err;
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  // Zero-wait-state request table: store, load, byte store lane 0, load.
  logic        t_wr  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic        t_md  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] t_wd  [4] = '{32'hCAFEF00D, 32'h0, 32'h00000077, 32'h0};
  logic [31:0] t_exp [4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF077};

  initial begin
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_mode = 1'b0;
    bus0.req_byte_sel = 2'd0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.rsp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_mode = 1'b0;
    bus1.req_byte_sel = 2'd0; bus1.req_addr = '0; bus1.req_wdata = '0;

    #2;
    check("rst req_ready", bus0.req_ready, 1);
    check("rst rsp_valid", bus0.rsp_valid, 0);
    check("rst rsp_rdata", bus0.rsp_rdata, 0);
    check("rst rsp_err",   bus0.rsp_err,   0);
    check("rst busy",      busy0,          0);
    check("rst req_ready w0", bus1.req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Word store then load
    do_req(1'b1, 1'b0, 2'd0, 6'd5, 32'hDEADBEEF, rd, er, lat);
    check("st5 latency", lat, 3);
    check("st5 err",     er,  0);
    check("st5 rdata",   rd,  0);
    do_req(1'b0, 1'b0, 2'd0, 6'd5, 32'h0, rd, er, lat);
    check("ld5 rdata",   rd,  32'hDEADBEEF);
    check("ld5 latency", lat, 3);

    // Byte lanes
    do_req(1'b1, 1'b0, 2'd0, 6'd7, 32'h11223344, rd, er, lat);
    do_req(1'b1, 1'b1, 2'd2, 6'd7, 32'hFFFFFFAA, rd, er, lat);
    do_req(1'b0, 1'b0, 2'd0, 6'd7, 32'h0, rd, er, lat);
    check("ld7 word", rd, 32'h11AA3344);
    do_req(1'b0, 1'b1, 2'd3, 6'd7, 32'h0, rd, er, lat);
    check("ld7 lane3", rd, 32'h00000011);
    do_req(1'b0, 1'b1, 2'd2, 6'd7, 32'h0, rd, er, lat);
    check("ld7 lane2", rd, 32'h000000AA);

    // Address range boundaries
    do_req(1'b1, 1'b0, 2'd0, 6'd2, 32'h0BADF00D, rd, er, lat);
    do_req(1'b1, 1'b0, 2'd0, 6'd50, 32'h00000001, rd, er, lat);
    check("st50 err",   er, 1);
    check("st50 rdata", rd, 0);
    do_req(1'b0, 1'b0, 2'd0, 6'd2, 32'h0, rd, er, lat);
    check("ld2 unchanged", rd, 32'h0BADF00D);
    check("ld2 err",       er, 0);
    do_req(1'b1, 1'b0, 2'd0, 6'd47, 32'h47474747, rd, er, lat);
    check("st47 err", er, 0);
    do_req(1'b0, 1'b0, 2'd0, 6'd47, 32'h0, rd, er, lat);
    check("ld47 rdata", rd, 32'h47474747);
    do_req(1'b0, 1'b0, 2'd0, 6'd48, 32'h0, rd, er, lat);
    check("ld48 err",   er, 1);
    check("ld48 rdata", rd, 0);

    // Backpressure with ignored request pulses
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_mode = 1'b0; bus0.req_addr = 6'd5;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    for (int g = 0; g < 10 && !bus0.rsp_valid; g++) begin
      @(posedge clk); #1;
    end
    bus0.req_write = 1'b1; bus0.req_wdata = 32'h0; bus0.req_addr = 6'd5;
    for (int k = 0; k < 5; k++) begin
      bus0.req_valid = (k % 2 == 0);
      check("bp rsp_valid", bus0.rsp_valid, 1);
      check("bp rsp_rdata", bus0.rsp_rdata, 32'hDEADBEEF);
      check("bp rsp_err",   bus0.rsp_err,   0);
      check("bp req_ready", bus0.req_ready, 0);
      @(posedge clk); #1;
    end
    bus0.req_valid = 1'b0;
    check("bp held rdata", bus0.rsp_rdata, 32'hDEADBEEF);
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b0;
    check("bp release rsp_valid", bus0.rsp_valid, 0);
    check("bp release req_ready", bus0.req_ready, 1);
    do_req(1'b0, 1'b0, 2'd0, 6'd5, 32'h0, rd, er, lat);
    check("bp pulses ignored", rd, 32'hDEADBEEF);

    // Reset during WAIT
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_mode = 1'b0;
    bus0.req_addr = 6'd3; bus0.req_wdata = 32'h55;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    check("mid busy", busy0, 1);
    rst = 1'b0;
    #1;
    check("mid rst req_ready", bus0.req_ready, 1);
    check("mid rst rsp_valid", bus0.rsp_valid, 0);
    check("mid rst rsp_rdata", bus0.rsp_rdata, 0);
    check("mid rst busy",      busy0,          0);
    @(posedge clk); #1;
    rst = 1'b1;
    do_req(1'b0, 1'b0, 2'd0, 6'd3, 32'h0, rd, er, lat);
    check("ld3 after rst", rd, 0);
    check("first edge accept latency", lat, 3);
    do_req(1'b0, 1'b0, 2'd0, 6'd5, 32'h0, rd, er, lat);
    check("ld5 cleared", rd, 0);

    // Zero wait states, back-to-back requests
    begin
      int  idx;
      int  cyc;
      int  last_acc;
      logic pre;
      idx = 0; cyc = 0; last_acc = -10;
      while (idx < 4 && cyc < 30) begin
        bus1.req_valid    = 1'b1;
        bus1.req_write    = t_wr[idx];
        bus1.req_mode     = t_md[idx];
        bus1.req_byte_sel = 2'd0;
        bus1.req_addr     = 6'd9;
        bus1.req_wdata    = t_wd[idx];
        pre = bus1.req_ready && bus1.req_valid;
        @(posedge clk); #1;
        cyc++;
        check("w0 rsp_valid after edge", bus1.rsp_valid, pre);
        if (pre) begin
          check("w0 rsp_rdata", bus1.rsp_rdata, t_exp[idx]);
          if (idx > 0) check("w0 accept gap >= 2", (cyc - last_acc) >= 2, 1);
          last_acc = cyc;
          idx++;
        end
      end
      bus1.req_valid = 1'b0;
      check("w0 all accepted", idx, 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
